// File: rtl/traffic_lamp_monitor_pkg.sv
// rtl/traffic_lamp_monitor_pkg.sv - shared light codes, states, fault codes and conflict pairs
package traffic_pkg;

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_INVALID   = 3'd2;
    localparam logic [2:0] FC_ILLEGAL   = 3'd3;
    localparam logic [2:0] FC_SHORT_YEL = 3'd4;
    localparam logic [2:0] FC_STUCK_GRN = 3'd5;

    localparam int NUM_LANES = 4;
    localparam int LANE_M1   = 0;
    localparam int LANE_S    = 1;
    localparam int LANE_M2   = 2;
    localparam int LANE_MT   = 3;

    // Lanes that may not be green together with S, and together with MT.
    // M1 may share green with MT or M2.
    localparam logic [NUM_LANES-1:0] S_CONFLICTS  = 4'b1101;
    localparam logic [NUM_LANES-1:0] MT_CONFLICTS = 4'b0100;

    function automatic logic greens_conflict(input logic [NUM_LANES-1:0] grn);
        return (grn[LANE_S]  && (|(grn & S_CONFLICTS))) ||
               (grn[LANE_MT] && (|(grn & MT_CONFLICTS)));
    endfunction

    function automatic logic is_valid_code(input logic [2:0] code);
        return (code == RED) || (code == YEL) || (code == GRN);
    endfunction

endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// rtl/traffic_lamp_monitor_if.sv - controller codes in, lamp drive and fault status out
interface traffic_lamp_monitor_if;

    logic [2:0] light_M1;
    logic [2:0] light_S;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic       fault_clr;

    logic [2:0] lamp_M1;
    logic [2:0] lamp_S;
    logic [2:0] lamp_M2;
    logic [2:0] lamp_MT;
    logic       fault;
    logic [2:0] fault_code;

    // Controller / operator side
    modport master (
        output light_M1, light_S, light_M2, light_MT, fault_clr,
        input  lamp_M1, lamp_S, lamp_M2, lamp_MT, fault, fault_code
    );

    // Monitor side
    modport slave (
        input  light_M1, light_S, light_M2, light_MT, fault_clr,
        output lamp_M1, lamp_S, lamp_M2, lamp_MT, fault, fault_code
    );

endinterface

// File: rtl/traffic_lamp_monitor_lane_seq_checker.sv
// rtl/traffic_lamp_monitor_lane_seq_checker.sv - per-lane encoding, sequence and timing checks
module lane_seq_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_GREEN  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_i,
    output logic       invalid_o,
    output logic       illegal_o,
    output logic       short_yel_o,
    output logic       stuck_grn_o
);

    localparam int YW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
    localparam int GW = (MAX_GREEN > 0) ? $clog2(MAX_GREEN + 1) : 1;

    logic [2:0]    prev_q, prev_d;
    logic [YW-1:0] ycnt_q, ycnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          legal_step;

    // Only hold, RED->GRN, GRN->YEL and YEL->RED are permitted steps
    always_comb begin
        legal_step = (code_i == prev_q) ||
                     ((prev_q == RED) && (code_i == GRN)) ||
                     ((prev_q == GRN) && (code_i == YEL)) ||
                     ((prev_q == YEL) && (code_i == RED));
    end

    // Flags are raw; the top decides whether they matter in the current state
    always_comb begin
        invalid_o   = !is_valid_code(code_i);
        illegal_o   = is_valid_code(code_i) && !legal_step;
        short_yel_o = (prev_q == YEL) && (code_i == RED) && (ycnt_q < YW'(MIN_YELLOW));
        stuck_grn_o = (code_i == GRN) && (gcnt_q == GW'(MAX_GREEN));
    end

    // History tracks the raw input every cycle; run counters saturate
    always_comb begin
        prev_d = code_i;
        ycnt_d = '0;
        gcnt_d = '0;
        if (code_i == YEL) begin
            ycnt_d = (ycnt_q == YW'(MIN_YELLOW)) ? ycnt_q : ycnt_q + YW'(1);
        end
        if (code_i == GRN) begin
            gcnt_d = (gcnt_q == GW'(MAX_GREEN)) ? gcnt_q : gcnt_q + GW'(1);
        end
    end

    // History registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= RED;
            ycnt_q <= '0;
            gcnt_q <= '0;
        end else begin
            prev_q <= prev_d;
            ycnt_q <= ycnt_d;
            gcnt_q <= gcnt_d;
        end
    end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// rtl/traffic_lamp_monitor.sv - lamp driver with conflict checks, fault latch and flash/recover FSM
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW  = 3,
    parameter int MAX_GREEN   = 60,
    parameter int FLASH_HALF  = 1,
    parameter int ALLRED_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_lamp_monitor_if.slave bus
);

    localparam int FW = (2 * FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
    localparam int HW = (ALLRED_HOLD > 0) ? $clog2(ALLRED_HOLD + 1) : 1;
    localparam logic [NUM_LANES-1:0][2:0] ALL_RED = {NUM_LANES{RED}};
    localparam logic [NUM_LANES-1:0][2:0] ALL_OFF = {NUM_LANES{DARK}};

    logic [NUM_LANES-1:0][2:0] light;
    logic [NUM_LANES-1:0]      grn;
    logic                      all_red;
    logic [NUM_LANES-1:0]      lane_invalid;
    logic [NUM_LANES-1:0]      lane_illegal;
    logic [NUM_LANES-1:0]      lane_short_yel;
    logic [NUM_LANES-1:0]      lane_stuck_grn;
    logic [2:0]                viol_code;

    state_e                    state_q, state_d;
    logic [HW-1:0]             hold_q, hold_d;
    logic [FW-1:0]             fcnt_q, fcnt_d;
    logic [2:0]                fault_code_q, fault_code_d;
    logic [NUM_LANES-1:0][2:0] lamp_q, lamp_d;

    assign light = {bus.light_MT, bus.light_M2, bus.light_S, bus.light_M1};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            lane_seq_checker #(
                .MIN_YELLOW (MIN_YELLOW),
                .MAX_GREEN  (MAX_GREEN)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .code_i      (light[g]),
                .invalid_o   (lane_invalid[g]),
                .illegal_o   (lane_illegal[g]),
                .short_yel_o (lane_short_yel[g]),
                .stuck_grn_o (lane_stuck_grn[g])
            );
        end
    endgenerate

    // Green map and all-red detection across the four lanes
    always_comb begin
        grn     = '0;
        all_red = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            grn[i] = (light[i] == GRN);
            if (light[i] != RED) begin
                all_red = 1'b0;
            end
        end
    end

    // Lowest fault code wins when several checks fire together
    always_comb begin
        viol_code = FC_NONE;
        if (greens_conflict(grn)) begin
            viol_code = FC_CONFLICT;
        end else if (|lane_invalid) begin
            viol_code = FC_INVALID;
        end else if (|lane_illegal) begin
            viol_code = FC_ILLEGAL;
        end else if (|lane_short_yel) begin
            viol_code = FC_SHORT_YEL;
        end else if (|lane_stuck_grn) begin
            viol_code = FC_STUCK_GRN;
        end
    end

    // Next state, fault latch, flash phase, recovery hold and lamp drive
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        fcnt_d       = fcnt_q;
        fault_code_d = fault_code_q;
        lamp_d       = lamp_q;
        case (state_q)
            NORMAL: begin
                if (viol_code != FC_NONE) begin
                    state_d      = FLASH;
                    fault_code_d = viol_code;
                    fcnt_d       = '0;
                    lamp_d       = ALL_RED;
                end else begin
                    lamp_d = light;
                end
            end
            FLASH: begin
                if (bus.fault_clr && all_red) begin
                    state_d      = RECOVER;
                    fault_code_d = FC_NONE;
                    hold_d       = '0;
                    lamp_d       = ALL_RED;
                end else begin
                    fcnt_d = (fcnt_q == FW'(2 * FLASH_HALF - 1)) ? '0 : fcnt_q + FW'(1);
                    lamp_d = (fcnt_d < FW'(FLASH_HALF)) ? ALL_RED : ALL_OFF;
                end
            end
            RECOVER: begin
                if (viol_code != FC_NONE) begin
                    state_d      = FLASH;
                    fault_code_d = viol_code;
                    fcnt_d       = '0;
                    lamp_d       = ALL_RED;
                end else begin
                    lamp_d = ALL_RED;
                    if (!all_red) begin
                        hold_d = '0;
                    end else if (hold_q == HW'(ALLRED_HOLD - 1)) begin
                        state_d = NORMAL;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = RECOVER;
                hold_d  = '0;
                lamp_d  = ALL_RED;
            end
        endcase
    end

    // State and output registers; reset lands in RECOVER with all lamps red
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RECOVER;
            hold_q       <= '0;
            fcnt_q       <= '0;
            fault_code_q <= FC_NONE;
            lamp_q       <= ALL_RED;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            fcnt_q       <= fcnt_d;
            fault_code_q <= fault_code_d;
            lamp_q       <= lamp_d;
        end
    end

    assign bus.lamp_M1    = lamp_q[LANE_M1];
    assign bus.lamp_S     = lamp_q[LANE_S];
    assign bus.lamp_M2    = lamp_q[LANE_M2];
    assign bus.lamp_MT    = lamp_q[LANE_MT];
    assign bus.fault      = (state_q == FLASH);
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb/tb_traffic_lamp_monitor.sv - directed bench with a rule-level model checked every cycle
module tb_traffic_lamp_monitor;

    localparam int MIN_YELLOW  = 3;
    localparam int MAX_GREEN   = 60;
    localparam int FLASH_HALF  = 1;
    localparam int ALLRED_HOLD = 2;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    localparam int MODE_PASS  = 0;
    localparam int MODE_FLASH = 1;
    localparam int MODE_HOLD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    traffic_lamp_monitor_if bus();

    traffic_lamp_monitor #(
        .MIN_YELLOW  (MIN_YELLOW),
        .MAX_GREEN   (MAX_GREEN),
        .FLASH_HALF  (FLASH_HALF),
        .ALLRED_HOLD (ALLRED_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode;
    int         m_cycle;
    int         m_entry;
    int         m_redrun;
    logic [2:0] m_code;
    logic [2:0] m_prev [4];
    int         m_yrun [4];
    int         m_grun [4];
    logic [2:0] e_lamp [4];

    function automatic int rule_violation(input logic [2:0] cur [4]);
        bit inv, ill, shrt, stk;
        bit g0, g1, g2, g3;
        g0 = (cur[0] == G); g1 = (cur[1] == G); g2 = (cur[2] == G); g3 = (cur[3] == G);
        if ((g1 && (g0 || g2 || g3)) || (g3 && g2)) return 1;
        inv = 0; ill = 0; shrt = 0; stk = 0;
        for (int i = 0; i < 4; i++) begin
            if (cur[i] != R && cur[i] != Y && cur[i] != G) inv = 1;
            else if (cur[i] != m_prev[i] &&
                     !((m_prev[i] == R && cur[i] == G) ||
                       (m_prev[i] == G && cur[i] == Y) ||
                       (m_prev[i] == Y && cur[i] == R))) ill = 1;
            if (m_prev[i] == Y && cur[i] == R && m_yrun[i] < MIN_YELLOW) shrt = 1;
            if (cur[i] == G && m_grun[i] >= MAX_GREEN) stk = 1;
        end
        if (inv) return 2;
        if (ill) return 3;
        if (shrt) return 4;
        if (stk) return 5;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [2:0] cur [4];
        int         v;
        bit         allred;
        int         k;
        if (!rst) begin
            m_mode = MODE_HOLD; m_redrun = 0; m_code = 3'd0; m_cycle = 0; m_entry = 0;
            for (int i = 0; i < 4; i++) begin
                e_lamp[i] = R; m_prev[i] = R; m_yrun[i] = 0; m_grun[i] = 0;
            end
        end else begin
            cur[0] = bus.light_M1; cur[1] = bus.light_S; cur[2] = bus.light_M2; cur[3] = bus.light_MT;
            v = rule_violation(cur);
            allred = (cur[0] == R) && (cur[1] == R) && (cur[2] == R) && (cur[3] == R);
            if (m_mode != MODE_FLASH && v != 0) begin
                m_mode = MODE_FLASH; m_code = v[2:0]; m_entry = m_cycle;
                for (int i = 0; i < 4; i++) e_lamp[i] = R;
            end else if (m_mode == MODE_PASS) begin
                for (int i = 0; i < 4; i++) e_lamp[i] = cur[i];
            end else if (m_mode == MODE_FLASH) begin
                if (bus.fault_clr && allred) begin
                    m_mode = MODE_HOLD; m_code = 3'd0; m_redrun = 0;
                    for (int i = 0; i < 4; i++) e_lamp[i] = R;
                end else begin
                    k = m_cycle - m_entry;
                    for (int i = 0; i < 4; i++) e_lamp[i] = (((k / FLASH_HALF) % 2) == 0) ? R : D;
                end
            end else begin
                for (int i = 0; i < 4; i++) e_lamp[i] = R;
                if (allred) begin
                    m_redrun++;
                    if (m_redrun >= ALLRED_HOLD) m_mode = MODE_PASS;
                end else begin
                    m_redrun = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_yrun[i] = (cur[i] == Y) ? m_yrun[i] + 1 : 0;
                m_grun[i] = (cur[i] == G) ? m_grun[i] + 1 : 0;
                m_prev[i] = cur[i];
            end
            m_cycle++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("lamp_M1", bus.lamp_M1, e_lamp[0]);
            check("lamp_S", bus.lamp_S, e_lamp[1]);
            check("lamp_M2", bus.lamp_M2, e_lamp[2]);
            check("lamp_MT", bus.lamp_MT, e_lamp[3]);
            check("fault", {2'b00, bus.fault}, {2'b00, (m_mode == MODE_FLASH)});
            check("fault_code", bus.fault_code, m_code);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [2:0] m1, input logic [2:0] s, input logic [2:0] m2,
                        input logic [2:0] mt, input logic clr);
        @(negedge clk);
        bus.light_M1 = m1; bus.light_S = s; bus.light_M2 = m2; bus.light_MT = mt;
        bus.fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_and_recover();
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b1);
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
    endtask

    initial begin
        bus.light_M1 = R; bus.light_S = R; bus.light_M2 = R; bus.light_MT = R;
        bus.fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_lamp_M1", bus.lamp_M1, R);
        check("rst_fault", {2'b00, bus.fault}, 3'd0);
        check("rst_code", bus.fault_code, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        // two all-red edges, then pass-through from the third
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        step(G, R, R, R, 1'b0);
        check("pass_start_M1", bus.lamp_M1, G);

        // legal M1 cycle, then S cycle, then M1+MT together
        repeat (9) step(G, R, R, R, 1'b0);
        repeat (3) step(Y, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        repeat (5) step(R, G, R, R, 1'b0);
        check("s_green", bus.lamp_S, G);
        repeat (3) step(R, Y, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        repeat (2) step(G, R, R, G, 1'b0);
        repeat (3) step(Y, R, R, Y, 1'b0);
        step(R, R, R, R, 1'b0);
        check("legal_fault", {2'b00, bus.fault}, 3'd0);

        // S and M1 green together
        step(G, G, R, R, 1'b0);
        check("conf_fault", {2'b00, bus.fault}, 3'd1);
        check("conf_code", bus.fault_code, 3'd1);
        check("conf_lamp_S", bus.lamp_S, R);
        step(G, G, R, R, 1'b0);
        check("flash_off", bus.lamp_M1, D);
        step(G, G, R, R, 1'b1);
        check("clr_ignored", {2'b00, bus.fault}, 3'd1);
        check("flash_on", bus.lamp_M1, R);
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b1);
        check("clr_fault", {2'b00, bus.fault}, 3'd0);
        check("clr_code", bus.fault_code, 3'd0);
        step(G, R, R, R, 1'b0);
        check("recover_red", bus.lamp_M1, R);
        repeat (3) step(Y, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        step(G, R, R, R, 1'b0);
        check("recover_done", bus.lamp_M1, G);
        repeat (3) step(Y, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);

        // short yellow on M2
        step(R, R, G, R, 1'b0);
        repeat (2) step(R, R, Y, R, 1'b0);
        step(R, R, R, R, 1'b0);
        check("short_yel_code", bus.fault_code, 3'd4);
        clear_and_recover();

        // GRN->RED on M2
        step(R, R, G, R, 1'b0);
        step(R, R, R, R, 1'b0);
        check("illegal_code", bus.fault_code, 3'd3);
        clear_and_recover();

        // invalid code on MT
        step(R, R, R, 3'b011, 1'b0);
        check("invalid_code", bus.fault_code, 3'd2);
        check("invalid_lamp", bus.lamp_MT, R);
        clear_and_recover();

        // stuck green on M1
        repeat (60) step(G, R, R, R, 1'b0);
        check("green60_ok", {2'b00, bus.fault}, 3'd0);
        step(G, R, R, R, 1'b0);
        check("stuck_code", bus.fault_code, 3'd5);
        step(G, R, R, R, 1'b0);

        // asynchronous reset in the middle of flashing
        rst = 1'b0;
        #1;
        check("midrst_lamp", bus.lamp_M1, R);
        check("midrst_fault", {2'b00, bus.fault}, 3'd0);
        check("midrst_code", bus.fault_code, 3'd0);
        @(negedge clk);
        bus.light_M1 = R;
        rst = 1'b1;
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        step(R, G, R, R, 1'b0);
        check("post_rst_pass", bus.lamp_S, G);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Safety monitor and lamp driver that sits directly downstream of the traffic light controller. It consumes the four 3-bit light codes (M1, S, M2, MT), checks every cycle for conflicting greens, invalid encodings, illegal sequences, short yellows and stuck greens, and drives the physical lamp outputs. Legal codes are passed through with one register of latency. On any violation it latches a fault code and forces all lamps to flashing red until an operator clear is accepted and an all-red recovery interval completes.

## Interface
Parameters:
- MIN_YELLOW, 3: minimum consecutive yellow cycles before yellow→red.
- MAX_GREEN, 60: maximum consecutive green cycles per lane.
- FLASH_HALF, 1: cycles red-on and cycles red-off in flash mode.
- ALLRED_HOLD, 2: consecutive all-red input cycles required to leave recovery.

Ports:
- clk  in  1  system clock (1 cycle = 1 s in system use).
- rst  in  1  reset; asynchronous, active-low.
- light_M1, light_S, light_M2, light_MT  in  3 each  controller codes.
- fault_clr  in  1  single-cycle operator clear request.
- lamp_M1, lamp_S, lamp_M2, lamp_MT  out  3 each  registered lamp drive.
- fault  out  1  high while in FLASH.
- fault_code  out  3  latched cause: 0 none, 1 conflict, 2 invalid code, 3 illegal transition, 4 short yellow, 5 stuck green.

## Operation
- Encoding: RED=3'b100, YEL=3'b010, GRN=3'b001. Any other value is invalid (code 2).
- Conflicts (code 1): S green together with any of M1/M2/MT green; MT green together with M2 green. M1+MT green and M1+M2 green are legal.
- Per lane, a previous-code register. Legal transitions: same→same, RED→GRN, GRN→YEL, YEL→RED. All others are code 3.
- ycnt per lane counts consecutive yellow cycles, saturating. YEL→RED with ycnt<MIN_YELLOW is code 4.
- gcnt counts consecutive prior green cycles, saturating at MAX_GREEN. Green input with gcnt==MAX_GREEN is code 5, so the (MAX_GREEN+1)th green cycle faults.
- Several violations in one cycle: the lowest code wins.
- States:
  - NORMAL: lamps <= inputs. A violation moves to FLASH.
  - FLASH: checks disabled; fault=1; lamps show flashing red. fault_clr while all four inputs are RED moves to RECOVER, clears fault and sets fault_code=0. fault_clr otherwise is ignored.
  - RECOVER: lamps all RED; hold counter increments per all-red input cycle and resets to 0 on any non-red input. Any violation moves back to FLASH. Counter reaching ALLRED_HOLD moves to NORMAL.
- Flash pattern: red bit on for FLASH_HALF cycles, then off (3'b000) for FLASH_HALF cycles, starting on at the entry edge. Yellow and green bits are 0.
- Previous-code registers and counters update every cycle in all states.

## Timing
- Reset: state=RECOVER, hold count 0, all lamps 3'b100, fault=0, fault_code=0, prev codes RED, counters 0.
- After reset release with all-red inputs, NORMAL is entered at the ALLRED_HOLD-th edge. Pass-through begins at the following edge.
- NORMAL latency: input sampled at edge k appears on lamps after edge k.
- Checks are combinational on current inputs plus registered history. On a violating edge, lamps load the flash-on pattern instead of the input, so a violating combination never reaches a lamp. fault and fault_code update on that same edge.
- fault_clr is acted on at the edge where it is sampled high.
- Reset asserted mid-flash or mid-recovery returns immediately to the reset values above.

## Structure
- traffic_pkg holds:
  - light code constants RED/YEL/GRN.
  - state enum {NORMAL, FLASH, RECOVER}.
  - fault code constants.
  - conflict-pair definition.
- Sub-module lane_seq_checker, instantiated four times: holds prev code, ycnt and gcnt. It flags codes 2–5 for one lane.
- The top level does the conflict check, priority select, FSM, flash timer and lamp registers.

## Test plan
- Reset, all inputs RED for 3 cycles -> lamps 3'b100 throughout; pass-through starts at cycle 3; fault=0.
- Legal cycle: M1 GRN 10, YEL 3, RED; then S GRN -> lamps mirror inputs one cycle late; fault stays 0.
- S and M1 both GRN in one cycle -> fault=1, fault_code=1 on that edge; lamps 3'b100/3'b000 alternating every cycle; GRN never appears on lamps.
- M2 YEL for 2 cycles then RED -> fault_code=4. Separately, M2 GRN→RED -> fault_code=3. Separately, light_MT=3'b011 -> fault_code=2.
- M1 GRN for 61 consecutive cycles -> fault_code=5 on the 61st green edge.
- In FLASH, fault_clr with S=GRN -> ignored. Then all RED plus fault_clr -> RECOVER and fault=0. One non-red cycle restarts the hold count. 2 all-red cycles -> NORMAL.
